// File: rtl/vga_sprite_if.sv
// Signals between the VGA timing / image ROM side (master) and the sprite engine (slave).
interface vga_sprite_if #(
  parameter int ADDR_W = 15
);
  logic [10:0]       hc;
  logic [10:0]       vc;
  logic              blank;
  logic [10:0]       pos_x;
  logic [10:0]       pos_y;
  logic [7:0]        mem_value;
  logic [ADDR_W-1:0] rom_addr;
  logic [2:0]        R;
  logic [2:0]        G;
  logic [1:0]        B;
  logic              inside_image;
  logic              blank_out;

  modport master (
    output hc, vc, blank, pos_x, pos_y, mem_value,
    input  rom_addr, R, G, B, inside_image, blank_out
  );

  modport slave (
    input  hc, vc, blank, pos_x, pos_y, mem_value,
    output rom_addr, R, G, B, inside_image, blank_out
  );
endinterface

// File: rtl/vga_sprite_engine.sv
// Maps the raster position onto a scaled, movable ROM sprite and emits keyed 3-3-2 RGB
// aligned with a delayed blank; latency from hc/vc to RGB is ROM_LAT+2 cycles.
module vga_sprite_engine #(
  parameter int         VGA_WIDTH  = 640,
  parameter int         VGA_HEIGHT = 480,
  parameter int         IMG_WIDTH  = 181,
  parameter int         IMG_HEIGHT = 181,
  parameter int         SCALE      = 1,
  parameter int         ADDR_W     = 15,
  parameter int         ROM_LAT    = 1,
  parameter bit         TRANSP_EN  = 1'b1,
  parameter logic [7:0] TRANSP_KEY = 8'hE3,
  parameter int         DEF_X      = (VGA_WIDTH - IMG_WIDTH*SCALE)/2,
  parameter int         DEF_Y      = (VGA_HEIGHT - IMG_HEIGHT*SCALE)/2
) (
  input logic         clk,
  input logic         rst,
  vga_sprite_if.slave bus
);

  logic [10:0]       cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic              frame_ok_q, frame_ok_d;
  logic              v_in_q, v_in_d;
  logic [3:0]        rsub_q, rsub_d;
  logic [10:0]       row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              h_in_q, h_in_d;
  logic [3:0]        csub_q, csub_d;
  logic [10:0]       col_q, col_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_LAT:0]  hit_pipe_q, hit_pipe_d;
  logic [ROM_LAT:0]  blank_pipe_q, blank_pipe_d;
  logic [7:0]        rgb_q, rgb_d;
  logic              inside_q, inside_d;
  logic              blank_out_q, blank_out_d;
  logic              frame_start, hit_now, opaque;

  always_comb begin
    frame_start = (bus.hc == '0) && (bus.vc == '0);
    cur_x_d     = frame_start ? bus.pos_x : cur_x_q;
    cur_y_d     = frame_start ? bus.pos_y : cur_y_q;
    // nothing is drawn after a reset until a full frame start has been seen
    frame_ok_d  = frame_ok_q | frame_start;

    v_in_d     = v_in_q;
    rsub_d     = rsub_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    if (bus.hc == '0) begin
      if (frame_ok_d && (bus.vc == cur_y_d)) begin
        v_in_d     = 1'b1;
        rsub_d     = '0;
        row_d      = '0;
        row_base_d = '0;
      end else if (v_in_q) begin
        if (rsub_q == 4'(SCALE-1)) begin
          rsub_d = '0;
          if (row_q == 11'(IMG_HEIGHT-1)) begin
            v_in_d = 1'b0;
          end else begin
            row_d      = row_q + 11'd1;
            row_base_d = row_base_q + ADDR_W'(IMG_WIDTH);
          end
        end else begin
          rsub_d = rsub_q + 4'd1;
        end
      end
    end

    // horizontal start sees the vertical update of the same cycle
    h_in_d = h_in_q;
    csub_d = csub_q;
    col_d  = col_q;
    if (bus.hc == cur_x_d) begin
      h_in_d = 1'b1;
      csub_d = '0;
      col_d  = '0;
    end else if (h_in_q) begin
      if (csub_q == 4'(SCALE-1)) begin
        csub_d = '0;
        if (col_q == 11'(IMG_WIDTH-1)) h_in_d = 1'b0;
        else                           col_d  = col_q + 11'd1;
      end else begin
        csub_d = csub_q + 4'd1;
      end
    end

    hit_now      = h_in_d && v_in_d && !bus.blank && (bus.hc < 11'(VGA_WIDTH));
    rom_addr_d   = hit_now ? (row_base_d + ADDR_W'(col_d)) : '0;
    hit_pipe_d   = {hit_pipe_q[ROM_LAT-1:0], hit_now};
    blank_pipe_d = {blank_pipe_q[ROM_LAT-1:0], bus.blank};

    opaque = !(TRANSP_EN && (bus.mem_value == TRANSP_KEY));
    if (hit_pipe_q[ROM_LAT] && opaque) begin
      rgb_d    = bus.mem_value;
      inside_d = 1'b1;
    end else begin
      rgb_d    = '0;
      inside_d = 1'b0;
    end
    blank_out_d = blank_pipe_q[ROM_LAT];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x_q      <= 11'(DEF_X);
      cur_y_q      <= 11'(DEF_Y);
      frame_ok_q   <= 1'b0;
      v_in_q       <= 1'b0;
      rsub_q       <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      h_in_q       <= 1'b0;
      csub_q       <= '0;
      col_q        <= '0;
      rom_addr_q   <= '0;
      hit_pipe_q   <= '0;
      blank_pipe_q <= '1;
      rgb_q        <= '0;
      inside_q     <= 1'b0;
      blank_out_q  <= 1'b1;
    end else begin
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      frame_ok_q   <= frame_ok_d;
      v_in_q       <= v_in_d;
      rsub_q       <= rsub_d;
      row_q        <= row_d;
      row_base_q   <= row_base_d;
      h_in_q       <= h_in_d;
      csub_q       <= csub_d;
      col_q        <= col_d;
      rom_addr_q   <= rom_addr_d;
      hit_pipe_q   <= hit_pipe_d;
      blank_pipe_q <= blank_pipe_d;
      rgb_q        <= rgb_d;
      inside_q     <= inside_d;
      blank_out_q  <= blank_out_d;
    end
  end

  assign bus.rom_addr     = rom_addr_q;
  assign bus.R            = rgb_q[7:5];
  assign bus.G            = rgb_q[4:2];
  assign bus.B            = rgb_q[1:0];
  assign bus.inside_image = inside_q;
  assign bus.blank_out    = blank_out_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Four engines (scale 1/2, ROM latency 1/3, key on/off) share one reduced raster and are
// compared every cycle against an arithmetic sprite model, plus literal spot values.
module tb_vga_sprite_engine;
  localparam int         VW  = 400;
  localparam int         VH  = 10;
  localparam int         HT  = 600;
  localparam int         VT  = 12;
  localparam int         IW  = 181;
  localparam int         IH  = 4;
  localparam int         AW  = 15;
  localparam logic [7:0] KEY = 8'hE3;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hc_s, vc_s, pos_x, pos_y;
  logic        blank_s;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] rom_word(input int a);
    if (a == 5) return KEY;
    return 8'((a*29 + 7) % 256);
  endfunction

  function automatic int sc(input int i); return (i == 1) ? 2 : 1; endfunction
  function automatic int lt(input int i); return (i == 2) ? 3 : 1; endfunction
  function automatic bit te(input int i); return (i == 3) ? 1'b0 : 1'b1; endfunction

  vga_sprite_if #(.ADDR_W(AW)) bus [4] ();

  logic [AW-1:0] ra  [4];
  logic [7:0]    rgb [4];
  logic          ins [4];
  logic          bo  [4];

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int L = (i == 2) ? 3 : 1;
    logic [7:0] rp [3];

    assign bus[i].hc    = hc_s;
    assign bus[i].vc    = vc_s;
    assign bus[i].blank = blank_s;
    assign bus[i].pos_x = pos_x;
    assign bus[i].pos_y = pos_y;

    always @(posedge clk) begin
      rp[0] <= rom_word(int'(bus[i].rom_addr));
      rp[1] <= rp[0];
      rp[2] <= rp[1];
    end
    assign bus[i].mem_value = rp[L-1];

    assign ra[i]  = bus[i].rom_addr;
    assign rgb[i] = {bus[i].R, bus[i].G, bus[i].B};
    assign ins[i] = bus[i].inside_image;
    assign bo[i]  = bus[i].blank_out;

    vga_sprite_engine #(
      .VGA_WIDTH (VW),
      .VGA_HEIGHT(VH),
      .IMG_WIDTH (IW),
      .IMG_HEIGHT(IH),
      .SCALE     ((i == 1) ? 2 : 1),
      .ADDR_W    (AW),
      .ROM_LAT   (L),
      .TRANSP_EN ((i == 3) ? 1'b0 : 1'b1),
      .TRANSP_KEY(KEY)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus[i])
    );
  end

  // history ring, one entry per clock edge, holding the inputs and the model's verdict
  int h_hc [8];
  int h_vc [8];
  int h_fr [8];
  bit h_blank [8];
  bit h_rst [8];
  bit h_hit [4][8];
  int h_addr [4][8];

  int hcv, vcv, fr, cx, cy, e, last_e;
  bit fok, chk_en, prev_bo2;

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, last_e);
    end
  endtask

  task automatic drive_edge();
    int k, dx, dy, s;
    bit fs;
    k       = e % 8;
    fs      = (hcv == 0) && (vcv == 0);
    hc_s    = 11'(hcv);
    vc_s    = 11'(vcv);
    blank_s = (hcv >= VW) || (vcv >= VH);
    if (!rst && fs) begin
      cx  = int'(pos_x);
      cy  = int'(pos_y);
      fok = 1'b1;
    end
    h_hc[k] = hcv; h_vc[k] = vcv; h_fr[k] = fr;
    h_blank[k] = blank_s; h_rst[k] = rst;
    for (int i = 0; i < 4; i++) begin
      s  = sc(i);
      dx = hcv - cx;
      dy = vcv - cy;
      h_hit[i][k] = !rst && fok && !blank_s && (hcv < VW) &&
                    (dx >= 0) && (dx < IW*s) && (dy >= 0) && (dy < IH*s);
      h_addr[i][k] = h_hit[i][k] ? ((dy / s) * IW + dx / s) : 0;
    end
    if (rst) fok = 1'b0;
  endtask

  task automatic check_inst(input int i, input int n);
    int L, m, exp_ra, exp_rgb, exp_in, exp_bo;
    bit anyrst;
    logic [7:0] w;
    L      = lt(i);
    exp_ra = h_rst[n % 8] ? 0 : h_addr[i][n % 8];
    anyrst = (n - L - 1) < 0;
    for (int k = 0; k <= L + 1; k++)
      if (n - k >= 0 && h_rst[(n - k) % 8]) anyrst = 1'b1;
    exp_rgb = 0; exp_in = 0; exp_bo = 1;
    if (!anyrst) begin
      m      = (n - L - 1) % 8;
      w      = rom_word(h_addr[i][m]);
      exp_bo = int'(h_blank[m]);
      if (h_hit[i][m] && !(te(i) && w == KEY)) begin
        exp_rgb = int'(w);
        exp_in  = 1;
      end
    end
    lit($sformatf("u%0d_rom_addr", i), int'(ra[i]), exp_ra);
    lit($sformatf("u%0d_rgb", i), int'(rgb[i]), exp_rgb);
    lit($sformatf("u%0d_inside", i), int'(ins[i]), exp_in);
    lit($sformatf("u%0d_blank_out", i), int'(bo[i]), exp_bo);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int n, k, m1, m3;
      n = last_e;
      k = n % 8;
      for (int i = 0; i < 4; i++) check_inst(i, n);

      // pixel-address spot values
      if (h_fr[k] == 0 && h_vc[k] == 2 && h_hc[k] == 100) lit("t1_addr_first", int'(ra[0]), 0);
      if (h_fr[k] == 0 && h_vc[k] == 2 && h_hc[k] == 101) lit("t1_addr_second", int'(ra[0]), 1);
      if (h_fr[k] == 0 && h_vc[k] == 2 && h_hc[k] == 280) lit("t1_addr_last_col", int'(ra[0]), 180);
      if (h_fr[k] == 0 && h_vc[k] == 3 && h_hc[k] == 100) lit("t1_addr_row1", int'(ra[0]), 181);
      if (h_fr[k] == 1 && h_vc[k] == 5 && h_hc[k] == 100) lit("move_old_pos", int'(ra[0]), 543);
      if (h_fr[k] == 2 && h_vc[k] == 2 && h_hc[k] == 201) lit("move_new_pos", int'(ra[0]), 1);
      if (h_fr[k] == 3 && h_vc[k] == 0 && h_hc[k] <= 3)
        lit($sformatf("s2_addr_hc%0d", h_hc[k]), int'(ra[1]), h_hc[k] / 2);
      if (h_fr[k] == 3 && h_vc[k] == 1 && h_hc[k] == 5) lit("s2_line1_repeat", int'(ra[1]), 2);
      if (h_fr[k] == 3 && h_vc[k] == 2 && h_hc[k] == 0) lit("s2_line2_start", int'(ra[1]), 181);
      if (h_fr[k] == 4 && h_vc[k] == 3 && h_hc[k] == 50) begin
        lit("rst_addr", int'(ra[0]), 0);
        lit("rst_rgb", int'(rgb[0]), 0);
        lit("rst_inside", int'(ins[0]), 0);
        lit("rst_blank_out", int'(bo[0]), 1);
      end
      if (h_fr[k] == 4 && h_vc[k] == 3 && h_hc[k] == 60) lit("rst_no_draw", int'(ra[0]), 0);
      if (h_fr[k] == 5 && h_vc[k] == 3 && h_hc[k] == 60) lit("rst_next_frame", int'(ra[0]), 603);

      // output-side spot values, keyed on the pixel that produced them
      if (n >= 4) begin
        m1 = (n - 2) % 8;
        m3 = (n - 4) % 8;
        if (h_fr[m1] == 0 && h_vc[m1] == 2 && h_hc[m1] == 99) lit("t1_ins_before", int'(ins[0]), 0);
        if (h_fr[m1] == 0 && h_vc[m1] == 2 && h_hc[m1] == 281) lit("t1_ins_after", int'(ins[0]), 0);
        if (h_fr[m1] == 0 && h_vc[m1] == 2 && h_hc[m1] == 280) begin
          lit("t1_ins_last", int'(ins[0]), 1);
          lit("t1_rgb_last", int'(rgb[0]), 8'h6B);
        end
        if (h_fr[m1] == 0 && h_vc[m1] == 2 && h_hc[m1] == 105) begin
          lit("key_rgb", int'(rgb[0]), 0);
          lit("key_ins", int'(ins[0]), 0);
          lit("nokey_rgb", int'(rgb[3]), 8'hE3);
          lit("nokey_ins", int'(ins[3]), 1);
        end
        if (h_fr[m1] == 2 && h_vc[m1] == 2 && h_hc[m1] == 100) lit("move_old_gone", int'(ins[0]), 0);
        if (h_fr[m1] == 2 && h_vc[m1] == 2 && h_hc[m1] == 200) begin
          lit("move_new_ins", int'(ins[0]), 1);
          lit("move_new_rgb", int'(rgb[0]), 7);
        end
        if (h_fr[m1] == 3 && h_vc[m1] == 0 && h_hc[m1] == 361) lit("s2_span_end", int'(ins[1]), 1);
        if (h_fr[m1] == 3 && h_vc[m1] == 0 && h_hc[m1] == 362) lit("s2_span_past", int'(ins[1]), 0);
        if (h_fr[m3] == 3 && h_vc[m3] == 0 && h_hc[m3] == 0) begin
          lit("lat3_ins_first", int'(ins[2]), 1);
          lit("lat3_blank_fall", int'(bo[2]), 0);
          lit("lat3_blank_before", int'(prev_bo2), 1);
        end
      end
      prev_bo2 = bo[2];
    end
  end

  initial begin
    rst      = 1'b1;
    pos_x    = 11'd100;
    pos_y    = 11'd2;
    hcv      = HT - 6;
    vcv      = VT - 1;
    fr       = -1;
    fok      = 1'b0;
    cx       = 0;
    cy       = 0;
    e        = 0;
    last_e   = 0;
    chk_en   = 1'b0;
    prev_bo2 = 1'b1;
    while (!(fr == 6 && hcv == 20)) begin
      rst = (e < 4) || (fr == 4 && vcv == 3 && hcv == 50);
      if (fr == 1 && vcv == 5 && hcv == 0) pos_x = 11'd200;
      if (fr == 2 && vcv == 11 && hcv == 0) begin
        pos_x = 11'd0;
        pos_y = 11'd0;
      end
      drive_edge();
      @(posedge clk);
      #1;
      last_e = e;
      chk_en = 1'b1;
      e++;
      hcv++;
      if (hcv == HT) begin
        hcv = 0;
        vcv = (vcv == VT - 1) ? 0 : vcv + 1;
        if (vcv == 0) fr++;
      end
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_sprite_engine.md
Name: vga_sprite_engine

Overview:
- Pipelined, parametrised sprite renderer.
- Maps the current VGA pixel (hc, vc) onto a ROM-backed image placed at a runtime-movable position with integer scaling.
- Fetches the pixel through a ROM of configurable read latency, applies an optional transparency colour key, and outputs registered 3-3-2 RGB aligned with a delayed blank.
- Sits between vga_controller (timing) and the image ROM. It feeds the top-level colour mux.

Parameters:
- VGA_WIDTH, 640, active pixels per line.
- VGA_HEIGHT, 480, active lines per frame.
- IMG_WIDTH, 181, sprite width in ROM pixels.
- IMG_HEIGHT, 181, sprite height in ROM pixels.
- SCALE, 1, integer replication factor (1..15) in both axes.
- ADDR_W, 15, ROM address width; must hold IMG_WIDTH*IMG_HEIGHT-1.
- ROM_LAT, 1, ROM read latency in clk cycles (>=1).
- TRANSP_EN, 1, 1 enables the colour key.
- TRANSP_KEY, 8'hE3, 3-3-2 value treated as transparent.
- DEF_X, (VGA_WIDTH-IMG_WIDTH*SCALE)/2, reset-time sprite left edge.
- DEF_Y, (VGA_HEIGHT-IMG_HEIGHT*SCALE)/2, reset-time sprite top edge.

Ports:
- clk  in  1  pixel clock; hc advances by one per clk.
- rst  in  1  synchronous reset, active-high.
- hc  in  11  current horizontal pixel counter.
- vc  in  11  current vertical line counter.
- blank  in  1  high outside the active area.
- pos_x  in  11  requested sprite left edge.
- pos_y  in  11  requested sprite top edge.
- mem_value  in  8  ROM data, {R,G,B}.
- rom_addr  out  ADDR_W  ROM address (registered).
- R  out  3  red.
- G  out  3  green.
- B  out  2  blue.
- inside_image  out  1  high when the output pixel is an opaque sprite pixel.
- blank_out  out  1  blank delayed to align with R/G/B.

Behaviour:
- Reset: all of the following are cleared or loaded on the next rising clk:
  - rom_addr=0, R=G=B=0, inside_image=0, blank_out=1.
  - Position registers = DEF_X/DEF_Y.
  - Counters cleared; delay pipes flushed to "outside, blanked".
- Position latch: cur_x/cur_y load pos_x/pos_y only on the cycle hc==0 && vc==0. Changes mid-frame take effect next frame, which prevents tearing.
- Vertical tracking, evaluated only on cycles with hc==0:
  - vc==cur_y: v_in=1, rsub=0, row_base=0.
  - Otherwise, while v_in:
    - rsub increments.
    - On rsub==SCALE-1: rsub=0 and row_base += IMG_WIDTH.
    - After IMG_HEIGHT*SCALE lines, v_in=0.
- Horizontal tracking, every cycle:
  - hc==cur_x: h_in=1, csub=0, col=0.
  - Otherwise, while h_in:
    - csub increments.
    - On csub==SCALE-1: csub=0 and col++.
    - After IMG_WIDTH*SCALE pixels, h_in=0.
- Arithmetic: no multipliers. Address = row_base + col, computed in ADDR_W bits. The width must be sized so it never wraps.
- Stage 1 (cycle t+1):
  - rom_addr <= (h_in_now && v_in && !blank) ? row_base+col : 0.
  - hit flag piped alongside it.
- ROM returns mem_value ROM_LAT cycles after rom_addr changes. hit and blank travel through matching delay shift registers.
- Stage 2 (output register, cycle t+ROM_LAT+2): total latency from hc/vc to RGB is ROM_LAT+2 cycles.
  - hit && !(TRANSP_EN && mem_value==TRANSP_KEY): {R,G,B}=mem_value, inside_image=1.
  - Otherwise: {R,G,B}=0, inside_image=0.
  - blank_out = blank delayed by ROM_LAT+2.
- Clipping: sprite pixels that fall where blank=1, or off-screen because cur_x+IMG_WIDTH*SCALE > VGA_WIDTH, are never hits. Counters still advance, so the visible part stays correctly addressed.
- Position 0: cur_x==0 is valid. The first sprite pixel is at hc==0, with no "x==0 means outside" convention.
- Simultaneous events: hc==cur_x on the same cycle as the vertical update at hc==0 → the vertical update applies first, then the horizontal start.
- Reset mid-frame: the block resumes correct output from the next frame start. Until then v_in=0, so nothing is drawn.

Test Plan:
- SCALE=1, ROM_LAT=1, pos=(100,50); raster a frame → rom_addr=0 at the cycle after (hc=100,vc=50). At (hc=280,vc=50) rom_addr=180. At (100,51) rom_addr=181. RGB=ROM content 3 cycles after each hc; inside_image=0 at hc=99 and hc=281.
- SCALE=2, pos=(0,0) → rom_addr sequence 0,0,1,1,2,2… on line 0. Line 1 repeats line 0. Line 2 starts at 181. Sprite spans hc 0..361.
- Transparency: ROM word 5 = 8'hE3 → output pixel 5 has RGB=0, inside_image=0. TRANSP_EN=0 → RGB=E3, inside_image=1.
- Change pos_x 100→200 at vc=120 → remainder of frame still drawn at x=100; next frame drawn at x=200.
- ROM_LAT=3 → RGB and blank_out lag hc by 5 cycles. First visible sprite pixel aligns with blank_out falling edge when pos_x=0.
- Assert rst for 1 cycle at vc=200 → outputs zero/blanked next cycle. No sprite pixels until the following frame; that frame is correct.
